dmem_responder: RTL and testbench

Responder end of the data-memory bus driven by the single-cycle CPU. Returns read data combinationally in the same cycle and commits stores on the clock edge. The block contains a word-organised RAM and a small memory-mapped register window: cycle counter, output port, store counter, and sticky error status. It sits on the mother board beside the CPU and is the target for all load/store traffic.

---
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle CPU: word RAM plus a 16-byte
// register window (CYCLE, OUT, STCNT, STATUS), combinational loads, clocked stores.
module dmem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] addr,
    input  logic        write_enab,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_OUT    = 2'd1;
    localparam logic [1:0] OFF_STCNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // Bus protocol: no valid/ready; every cycle is a complete transaction,
    // a store commits on the edge where write_enab is high, loads never stall.

    logic [31:0]   mem [DEPTH];
    logic [31:0]   cycle_cnt;
    logic [31:0]   store_cnt;
    logic          mis_q;
    logic          rng_q;

    logic          ram_hit;
    logic          mmio_hit;
    logic          misaligned;
    logic [1:0]    reg_off;
    logic [AW-1:0] word_idx;
    logic          ram_we;
    logic          out_we;
    logic          status_we;
    logic          set_mis;
    logic          set_rng;
    logic          clr_mis;
    logic          clr_rng;

    assign ram_hit    = (addr < RAM_BYTES);
    assign mmio_hit   = (addr[31:4] == MMIO_BASE[31:4]);
    assign misaligned = (addr[1:0] != 2'b00);
    assign reg_off    = addr[3:2];
    assign word_idx   = addr[AW+1:2];

    assign ram_we    = write_enab && ram_hit && !misaligned;
    assign out_we    = write_enab && mmio_hit && !misaligned && (reg_off == OFF_OUT);
    assign status_we = write_enab && mmio_hit && !misaligned && (reg_off == OFF_STATUS);
    assign set_mis   = write_enab && misaligned;
    assign set_rng   = write_enab && !ram_hit && !mmio_hit;
    assign clr_mis   = status_we && write_data[0];
    assign clr_rng   = status_we && write_data[1];

    // RAM has no reset so its contents survive n_reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_idx] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cycle_cnt <= '0;
            store_cnt <= '0;
            mis_q     <= 1'b0;
            rng_q     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (ram_we) begin
                store_cnt <= store_cnt + 32'd1;
            end
            // A new error of the same bit overrides a simultaneous clear.
            mis_q     <= set_mis | (mis_q & ~clr_mis);
            rng_q     <= set_rng | (rng_q & ~clr_rng);
            out_valid <= out_we;
            if (out_we) begin
                out_data <= write_data;
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (ram_hit) begin
            read_data = mem[word_idx];
        end else if (mmio_hit) begin
            case (reg_off)
                OFF_CYCLE:  read_data = cycle_cnt;
                OFF_OUT:    read_data = out_data;
                OFF_STCNT:  read_data = store_cnt;
                OFF_STATUS: read_data = {30'd0, rng_q, mis_q};
                default:    read_data = '0;
            endcase
        end
    end

    assign err = mis_q | rng_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan sequence with literal expectations,
// then random traffic compared every cycle against a behavioural memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH     = 64;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FFF0;
    localparam logic [31:0] R_CYCLE   = MMIO_BASE + 32'h0;
    localparam logic [31:0] R_OUT     = MMIO_BASE + 32'h4;
    localparam logic [31:0] R_STCNT   = MMIO_BASE + 32'h8;
    localparam logic [31:0] R_STATUS  = MMIO_BASE + 32'hC;

    logic        clk;
    logic        n_reset;
    logic [31:0] addr;
    logic        write_enab;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Behavioural model state
    logic [31:0] m_mem [int];
    logic [31:0] m_cycle;
    logic [31:0] m_stcnt;
    logic [31:0] m_out_data;
    logic        m_out_valid;
    logic        m_mis;
    logic        m_rng;

    dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .addr       (addr),
        .write_enab (write_enab),
        .write_data (write_data),
        .read_data  (read_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .err        (err)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cycle     = '0;
        m_stcnt     = '0;
        m_out_data  = '0;
        m_out_valid = 1'b0;
        m_mis       = 1'b0;
        m_rng       = 1'b0;
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >> 4) == (MMIO_BASE >> 4);
    endfunction

    // Expected load value; returns 0 when the RAM word has never been written.
    function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
        int key;
        logic [31:0] off;
        v   = '0;
        key = int'(a >> 2);
        off = (a >> 2) & 32'd3;
        if (in_ram(a)) begin
            if (!m_mem.exists(key)) return 1'b0;
            v = m_mem[key];
        end else if (in_mmio(a)) begin
            if (off == 0)      v = m_cycle;
            else if (off == 1) v = m_out_data;
            else if (off == 2) v = m_stcnt;
            else               v = {30'd0, m_rng, m_mis};
        end
        return 1'b1;
    endfunction

    always @(negedge n_reset) model_reset();

    // Model advances one bus transaction per rising edge.
    always @(posedge clk) begin
        if (!n_reset) begin
            model_reset();
        end else begin
            m_out_valid = 1'b0;
            if (write_enab) begin
                if (addr[1:0] != 2'b00) begin
                    m_mis = 1'b1;
                end else if (in_ram(addr)) begin
                    m_mem[int'(addr >> 2)] = write_data;
                    m_stcnt = m_stcnt + 1;
                end else if (in_mmio(addr) && ((addr >> 2) & 32'd3) == 1) begin
                    m_out_data  = write_data;
                    m_out_valid = 1'b1;
                end else if (in_mmio(addr) && ((addr >> 2) & 32'd3) == 3) begin
                    if (write_data[0]) m_mis = 1'b0;
                    if (write_data[1]) m_rng = 1'b0;
                end
                if (!in_ram(addr) && !in_mmio(addr)) m_rng = 1'b1;
            end
            m_cycle = m_cycle + 1;
        end
    end

    // Scoreboard compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] v;
        if (cmp_en) begin
            if (exp_read(addr, v)) check("read_data", read_data, v);
            check("out_data", out_data, m_out_data);
            check("out_valid", {31'd0, out_valid}, {31'd0, m_out_valid});
            check("err", {31'd0, err}, {31'd0, m_mis | m_rng});
        end
    end

    // Driver: present one transaction just after a rising edge.
    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd);
        @(posedge clk);
        #1;
        addr       = a;
        write_enab = we;
        write_data = wd;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          k;

        n_reset    = 1'b0;
        addr       = '0;
        write_enab = 1'b0;
        write_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        cmp_en  = 1'b1;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);

        // CYCLE reads 5 in cycle 5 after release
        repeat (4) idle();
        drive(R_CYCLE, 1'b0, 32'h0);
        #1 check("cycle_5", read_data, 32'd5);

        // Store then load
        drive(32'h10, 1'b1, 32'hDEAD_BEEF);
        drive(32'h10, 1'b0, 32'h0);
        #1 check("ram_readback", read_data, 32'hDEAD_BEEF);
        drive(R_STCNT, 1'b0, 32'h0);
        #1 check("stcnt_1", read_data, 32'd1);
        check("err_clean", {31'd0, err}, 32'd0);
        drive(32'h12, 1'b0, 32'h0);
        #1 check("misaligned_load", read_data, 32'hDEAD_BEEF);

        // Same-cycle store and load sees the old word
        drive(32'h20, 1'b1, 32'h0);
        drive(32'h20, 1'b1, 32'h1);
        #1 check("same_cycle_old", read_data, 32'h0);
        drive(32'h20, 1'b0, 32'h0);
        #1 check("next_cycle_new", read_data, 32'h1);

        // Misaligned store dropped, MIS set, then W1C
        drive(32'h13, 1'b1, 32'h5555_5555);
        drive(32'h10, 1'b0, 32'h0);
        #1 check("mis_dropped", read_data, 32'hDEAD_BEEF);
        check("mis_err", {31'd0, err}, 32'd1);
        drive(R_STATUS, 1'b0, 32'h0);
        #1 check("status_mis", read_data, 32'h1);
        drive(R_STATUS, 1'b1, 32'h1);
        drive(R_STATUS, 1'b0, 32'h0);
        #1 check("status_cleared", read_data, 32'h0);
        check("err_cleared", {31'd0, err}, 32'd0);

        // Out-of-range store
        drive(32'h100, 1'b1, 32'h7);
        drive(32'h100, 1'b0, 32'h0);
        #1 check("oor_load_zero", read_data, 32'h0);
        drive(R_STATUS, 1'b0, 32'h0);
        #1 check("status_rng", read_data, 32'h2);
        drive(R_STATUS, 1'b1, 32'h2);
        drive(R_STATUS, 1'b0, 32'h0);
        #1 check("rng_cleared", read_data, 32'h0);

        // OUT register pulses
        drive(R_OUT, 1'b1, 32'hA5);
        #1 check("out_valid_pre", {31'd0, out_valid}, 32'd0);
        idle();
        #1 check("out_valid_pulse", {31'd0, out_valid}, 32'd1);
        check("out_data_a5", out_data, 32'hA5);
        idle();
        #1 check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        drive(R_OUT, 1'b1, 32'h1);
        drive(R_OUT, 1'b1, 32'h2);
        #1 check("b2b_valid_1", {31'd0, out_valid}, 32'd1);
        check("b2b_data_1", out_data, 32'h1);
        idle();
        #1 check("b2b_valid_2", {31'd0, out_valid}, 32'd1);
        check("b2b_data_2", out_data, 32'h2);
        idle();
        #1 check("b2b_valid_end", {31'd0, out_valid}, 32'd0);

        // Random traffic; RAM writes avoid word 4 so 0x10 survives for the reset test
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 3) begin
                a = 32'($urandom_range(8, DEPTH - 1)) * 4;
            end else if (k == 4) begin
                a = 32'($urandom_range(8, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            end else if (k <= 7) begin
                a = MMIO_BASE + 32'($urandom_range(0, 15));
            end else if (k == 8) begin
                a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000));
            end else begin
                a = $urandom | 32'h1000_0000;
            end
            drive(a, 1'($urandom_range(0, 1)), $urandom);
        end

        // Asynchronous reset mid-cycle with live state
        drive(32'h13, 1'b1, 32'h0);
        drive(R_OUT, 1'b1, 32'h9);
        drive(R_CYCLE, 1'b0, 32'h0);
        #1 check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        check("pre_reset_err", {31'd0, err}, 32'd1);
        #1 n_reset = 1'b0;
        #1 check("async_cycle", read_data, 32'h0);
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_out_data", out_data, 32'h0);
        check("async_err", {31'd0, err}, 32'd0);
        drive(R_STCNT, 1'b0, 32'h0);
        #1 check("async_stcnt", read_data, 32'h0);
        drive(R_STATUS, 1'b0, 32'h0);
        #1 check("async_status", read_data, 32'h0);
        @(posedge clk);
        #1 n_reset = 1'b1;
        drive(32'h10, 1'b0, 32'h0);
        #1 check("ram_survives_reset", read_data, 32'hDEAD_BEEF);
        drive(R_CYCLE, 1'b0, 32'h0);
        #1 check("cycle_after_release", read_data, 32'd2);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
